// File: rtl/binary_bbox_detect.sv
// Bounding-box and white-pixel count of a binary video stream, reported once per
// frame on the vsync rising edge that closes it.
module binary_bbox_detect #(
  parameter int CNT_W     = 11,
  parameter int PIX_CNT_W = 21,
  parameter int MIN_PIX   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vsync_in,
  input  logic                 hsync_in,
  input  logic                 de_in,
  input  logic                 pix_in,
  output logic [CNT_W-1:0]     x_min,
  output logic [CNT_W-1:0]     x_max,
  output logic [CNT_W-1:0]     y_min,
  output logic [CNT_W-1:0]     y_max,
  output logic [PIX_CNT_W-1:0] pix_count,
  output logic                 bbox_valid,
  output logic                 frame_done
);

  typedef enum logic {WAIT_SOF, ACCUM} state_t;

  localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};
  localparam logic [PIX_CNT_W-1:0] PIX_MAX = {PIX_CNT_W{1'b1}};
  localparam logic [PIX_CNT_W-1:0] MIN_THR = PIX_CNT_W'(MIN_PIX);

  state_t               state, state_nxt;
  logic                 vs_d, de_d, vs_rise, de_fall, latch;
  logic [CNT_W-1:0]     x_cnt, y_cnt;
  logic [CNT_W-1:0]     x_min_acc, x_max_acc, y_min_acc, y_max_acc;
  logic [PIX_CNT_W-1:0] cnt_acc;
  logic                 unused_hsync;

  assign unused_hsync = hsync_in;
  assign vs_rise = vsync_in & ~vs_d;
  assign de_fall = ~de_in & de_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT_SOF;
      vs_d  <= 1'b0;
      de_d  <= 1'b0;
    end else begin
      state <= state_nxt;
      vs_d  <= vsync_in;
      de_d  <= de_in;
    end
  end

  // The first vs_rise after reset only arms the block; the partial frame before it is dropped.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    case (state)
      WAIT_SOF: if (vs_rise) state_nxt = ACCUM;
      ACCUM:    if (vs_rise) latch = 1'b1;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (!de_in)                 x_cnt <= '0;
      else if (x_cnt != CNT_MAX)  x_cnt <= x_cnt + CNT_W'(1);
      if (vs_rise)                             y_cnt <= '0;
      else if (de_fall && (y_cnt != CNT_MAX))  y_cnt <= y_cnt + CNT_W'(1);
    end
  end

  // A white pixel in the vs_rise cycle is deliberately dropped: the clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n || vs_rise) begin
      x_min_acc <= CNT_MAX;
      x_max_acc <= '0;
      y_min_acc <= CNT_MAX;
      y_max_acc <= '0;
      cnt_acc   <= '0;
    end else if ((state == ACCUM) && de_in && pix_in) begin
      if (x_cnt < x_min_acc) x_min_acc <= x_cnt;
      if (x_cnt > x_max_acc) x_max_acc <= x_cnt;
      if (y_cnt < y_min_acc) y_min_acc <= y_cnt;
      if (y_cnt > y_max_acc) y_max_acc <= y_cnt;
      if (cnt_acc != PIX_MAX) cnt_acc <= cnt_acc + PIX_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      pix_count  <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= latch;
      if (latch) begin
        pix_count <= cnt_acc;
        if (cnt_acc == '0) begin
          x_min      <= '0;
          x_max      <= '0;
          y_min      <= '0;
          y_max      <= '0;
          bbox_valid <= 1'b0;
        end else begin
          x_min      <= x_min_acc;
          x_max      <= x_max_acc;
          y_min      <= y_min_acc;
          y_max      <= y_max_acc;
          bbox_valid <= (cnt_acc >= MIN_THR);
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_bbox_detect.sv
// Bench for binary_bbox_detect: two instances (MIN_PIX=1 and 16) see the same frames;
// expectations are computed by scanning a pixel image held in the bench.
module tb_binary_bbox_detect;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync_in = 1'b0, hsync_in = 1'b0, de_in = 1'b0, pix_in = 1'b0;

  logic [10:0] xmn1, xmx1, ymn1, ymx1, xmn16, xmx16, ymn16, ymx16;
  logic [20:0] cnt1, cnt16;
  logic        val1, val16, fd1, fd16;
  logic [65:0] o1, o16, prev1, prev16;

  int checks = 0;
  int errors = 0;

  logic img [0:7][0:7];
  int   img_w, img_h;

  always #5 clk = ~clk;

  binary_bbox_detect #(.CNT_W(11), .PIX_CNT_W(21), .MIN_PIX(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .hsync_in(hsync_in), .de_in(de_in),
    .pix_in(pix_in), .x_min(xmn1), .x_max(xmx1), .y_min(ymn1), .y_max(ymx1),
    .pix_count(cnt1), .bbox_valid(val1), .frame_done(fd1));

  binary_bbox_detect #(.CNT_W(11), .PIX_CNT_W(21), .MIN_PIX(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .hsync_in(hsync_in), .de_in(de_in),
    .pix_in(pix_in), .x_min(xmn16), .x_max(xmx16), .y_min(ymn16), .y_max(ymx16),
    .pix_count(cnt16), .bbox_valid(val16), .frame_done(fd16));

  assign o1  = {xmn1, xmx1, ymn1, ymx1, cnt1, val1};
  assign o16 = {xmn16, xmx16, ymn16, ymx16, cnt16, val16};

  // Reference: bounding box and count straight from the image contents.
  function automatic logic [65:0] model(input int min_pix);
    int cnt = 0, xa = 99, xb = -1, ya = 99, yb = -1;
    for (int r = 0; r < img_h; r++)
      for (int c = 0; c < img_w; c++)
        if (img[r][c]) begin
          cnt++;
          if (c < xa) xa = c;
          if (c > xb) xb = c;
          if (r < ya) ya = r;
          if (r > yb) yb = r;
        end
    if (cnt == 0) return '0;
    return {11'(xa), 11'(xb), 11'(ya), 11'(yb), 21'(cnt), (cnt >= min_pix)};
  endfunction

  task automatic step(input logic v, input logic d, input logic p);
    @(negedge clk);
    vsync_in = v; de_in = d; pix_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img(input int w, input int h);
    img_w = w; img_h = h;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = 1'b0;
  endtask

  task automatic send_frame();
    for (int r = 0; r < img_h; r++) begin
      for (int c = 0; c < img_w; c++) step(1'b0, 1'b1, img[r][c]);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_hold(input string name);
    checks += 2;
    if (o1 !== prev1) begin errors++; $display("FAIL %s hold m1: got %h want %h", name, o1, prev1); end
    if (o16 !== prev16) begin errors++; $display("FAIL %s hold m16: got %h want %h", name, o16, prev16); end
  endtask

  // Closes the frame with a one-cycle vsync and checks the reported stats and pulse width.
  task automatic check_frame(input string name);
    logic [65:0] e1, e16;
    e1 = model(1); e16 = model(16);
    check_hold(name);
    step(1'b1, 1'b0, 1'b0);
    checks += 4;
    if (fd1 !== 1'b1 || fd16 !== 1'b1) begin errors++; $display("FAIL %s done: got %b%b want 11", name, fd1, fd16); end
    if (o1 !== e1) begin errors++; $display("FAIL %s stats m1: got %h want %h", name, o1, e1); end
    if (o16 !== e16) begin errors++; $display("FAIL %s stats m16: got %h want %h", name, o16, e16); end
    step(1'b0, 1'b0, 1'b0);
    if (fd1 !== 1'b0 || fd16 !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b%b want 00", name, fd1, fd16); end
    prev1 = e1; prev16 = e16;
    check_hold(name);
  endtask

  task automatic vs_no_done(input string name);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (fd1 !== 1'b0 || fd16 !== 1'b0) begin errors++; $display("FAIL %s first_vs_done: got %b%b want 00", name, fd1, fd16); end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks += 2;
    if (o1 !== '0 || o16 !== '0) begin errors++; $display("FAIL reset outs: got %h %h want 0", o1, o16); end
    if (fd1 !== 1'b0 || fd16 !== 1'b0) begin errors++; $display("FAIL reset done: got %b%b want 00", fd1, fd16); end
    rst_n = 1'b1;
    prev1 = '0; prev16 = '0;
    step(1'b0, 1'b0, 1'b0);
    // partial white frame before the first vsync must be discarded
    clear_img(8, 2);
    for (int r = 0; r < 2; r++) for (int c = 0; c < 8; c++) img[r][c] = 1'b1;
    send_frame();
    vs_no_done("reset");
  endtask

  task automatic test_two_pixels();
    clear_img(8, 4);
    img[1][2] = 1'b1; img[3][5] = 1'b1;
    send_frame();
    check_frame("two_pixels");
  endtask

  task automatic test_black();
    clear_img(8, 4);
    send_frame();
    check_frame("black");
  endtask

  task automatic test_mid_reset();
    clear_img(8, 4);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) img[r][c] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    end
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (o1 !== '0 || o16 !== '0 || fd1 !== 1'b0) begin errors++; $display("FAIL mid_reset outs: got %h %h %b want 0", o1, o16, fd1); end
    rst_n = 1'b1;
    prev1 = '0; prev16 = '0;
    for (int c = 5; c < 8; c++) step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    vs_no_done("mid_reset");
    clear_img(6, 3);
    img[0][4] = 1'b1; img[2][1] = 1'b1; img[1][3] = 1'b1;
    send_frame();
    check_frame("mid_reset_A");
    clear_img(8, 4);
    img[3][7] = 1'b1;
    send_frame();
    check_frame("mid_reset_B");
  endtask

  task automatic test_clear();
    clear_img(8, 4);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) img[r][c] = 1'b1;
    send_frame();
    check_frame("all_white");
    clear_img(8, 4);
    img[0][7] = 1'b1;
    send_frame();
    check_frame("single_after_white");
  endtask

  task automatic test_long_vsync();
    logic [65:0] e1, e16;
    clear_img(7, 3);
    img[0][0] = 1'b1; img[2][6] = 1'b1;
    send_frame();
    e1 = model(1); e16 = model(16);
    check_hold("long_vs");
    step(1'b1, 1'b1, 1'b1);
    checks += 3;
    if (fd1 !== 1'b1 || fd16 !== 1'b1) begin errors++; $display("FAIL long_vs done: got %b%b want 11", fd1, fd16); end
    if (o1 !== e1) begin errors++; $display("FAIL long_vs stats m1: got %h want %h", o1, e1); end
    if (o16 !== e16) begin errors++; $display("FAIL long_vs stats m16: got %h want %h", o16, e16); end
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (fd1 !== 1'b0 || fd16 !== 1'b0) begin errors++; $display("FAIL long_vs extra_done cyc%0d: got %b%b want 00", k, fd1, fd16); end
    end
    step(1'b0, 1'b0, 1'b0);
    prev1 = e1; prev16 = e16;
    clear_img(8, 4);
    send_frame();
    check_frame("after_long_vs");
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      clear_img(int'($urandom_range(1, 8)), int'($urandom_range(1, 6)));
      for (int r = 0; r < img_h; r++)
        for (int c = 0; c < img_w; c++)
          img[r][c] = ($urandom_range(0, 3) == 0);
      send_frame();
      check_frame($sformatf("random%0d", f));
    end
  endtask

  initial begin
    test_reset();
    test_two_pixels();
    test_black();
    test_clear();
    test_long_vsync();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
